// File: rtl/datapath_pkg.sv
// rtl/datapath_pkg.sv - shared state, opcode, shift and ALU codes for the operand sequencer
package datapath_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD_A = 3'd1,
    ST_RD_B = 3'd2,
    ST_EXEC = 3'd3,
    ST_WB   = 3'd4
  } state_t;

  localparam logic [1:0] KIND_ALU  = 2'b00;
  localparam logic [1:0] KIND_CMP  = 2'b01;
  localparam logic [1:0] KIND_MOVI = 2'b10;
  localparam logic [1:0] KIND_RSVD = 2'b11;

  localparam logic [1:0] SH_NONE = 2'b00;
  localparam logic [1:0] SH_LSL1 = 2'b01;
  localparam logic [1:0] SH_LSR1 = 2'b10;
  localparam logic [1:0] SH_ASR1 = 2'b11;

  localparam logic [1:0] ALU_ADD  = 2'b00;
  localparam logic [1:0] ALU_SUB  = 2'b01;
  localparam logic [1:0] ALU_AND  = 2'b10;
  localparam logic [1:0] ALU_NOTB = 2'b11;

endpackage

// File: rtl/regfile.sv
// rtl/regfile.sv - 8x16 register file, one write port, one sequenced read port, one debug read port
module regfile (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [2:0]  waddr,
  input  logic [15:0] wdata,
  input  logic [2:0]  raddr,
  output logic [15:0] rdata,
  input  logic [2:0]  dbg_addr,
  output logic [15:0] dbg_data
);

  logic [15:0] mem [0:7];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Both reads are combinational, so a write becomes visible only after its edge.
  assign rdata    = mem[raddr];
  assign dbg_data = mem[dbg_addr];

endmodule

// File: rtl/operand_sequencer.sv
// rtl/operand_sequencer.sv - sequences register reads, external ALU execution and writeback
module operand_sequencer
  import datapath_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        op_valid,
  output logic        op_ready,
  input  logic [1:0]  op_kind,
  input  logic [1:0]  op_alu,
  input  logic [2:0]  op_rn,
  input  logic [2:0]  op_rm,
  input  logic [2:0]  op_rd,
  input  logic [1:0]  op_shift,
  input  logic [7:0]  op_imm8,
  output logic [15:0] alu_ain,
  output logic [15:0] alu_bin,
  output logic [1:0]  alu_op,
  input  logic [15:0] alu_out,
  input  logic [2:0]  alu_status,
  output logic [2:0]  status_q,
  output logic        done,
  input  logic [2:0]  dbg_addr,
  output logic [15:0] dbg_data
);

  state_t      state, state_nx;
  logic [1:0]  kind_q, alu_q, shift_q;
  logic [2:0]  rn_q, rm_q, rd_q;
  logic [7:0]  imm_q;
  logic [15:0] a_q, b_q, c_q;
  logic        accept, load_a, load_b, load_c, load_st, we;
  logic [2:0]  raddr;
  logic [15:0] rdata, shifted, imm_ext, wdata;

  assign op_ready = (state == ST_IDLE) && !reset;
  assign accept   = op_valid && op_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    done     = 1'b0;
    we       = 1'b0;
    load_a   = 1'b0;
    load_b   = 1'b0;
    load_c   = 1'b0;
    load_st  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          if (op_kind == KIND_MOVI || op_kind == KIND_RSVD) state_nx = ST_WB;
          else                                              state_nx = ST_RD_A;
        end
      end
      ST_RD_A: begin
        load_a   = 1'b1;
        state_nx = ST_RD_B;
      end
      ST_RD_B: begin
        load_b   = 1'b1;
        state_nx = ST_EXEC;
      end
      ST_EXEC: begin
        load_c = 1'b1;
        if (kind_q == KIND_CMP) begin
          load_st  = 1'b1;
          done     = 1'b1;
          state_nx = ST_IDLE;
        end else begin
          state_nx = ST_WB;
        end
      end
      ST_WB: begin
        // Reserved opcodes pass through here only to produce their done pulse.
        we       = (kind_q != KIND_RSVD);
        done     = 1'b1;
        state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      kind_q   <= '0;
      alu_q    <= '0;
      shift_q  <= '0;
      rn_q     <= '0;
      rm_q     <= '0;
      rd_q     <= '0;
      imm_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      c_q      <= '0;
      status_q <= '0;
    end else begin
      if (accept) begin
        kind_q  <= op_kind;
        alu_q   <= op_alu;
        shift_q <= op_shift;
        rn_q    <= op_rn;
        rm_q    <= op_rm;
        rd_q    <= op_rd;
        imm_q   <= op_imm8;
      end
      if (load_a)  a_q      <= rdata;
      if (load_b)  b_q      <= shifted;
      if (load_c)  c_q      <= alu_out;
      if (load_st) status_q <= alu_status;
    end
  end

  assign raddr = (state == ST_RD_B) ? rm_q : rn_q;

  always_comb begin
    shifted = rdata;
    case (shift_q)
      SH_LSL1: shifted = {rdata[14:0], 1'b0};
      SH_LSR1: shifted = {1'b0, rdata[15:1]};
      SH_ASR1: shifted = {rdata[15], rdata[15:1]};
      default: shifted = rdata;
    endcase
  end

  assign imm_ext = {{8{imm_q[7]}}, imm_q};
  assign wdata   = (kind_q == KIND_MOVI) ? imm_ext : c_q;

  assign alu_ain = a_q;
  assign alu_bin = b_q;
  assign alu_op  = alu_q;

  regfile u_regfile (
    .clk      (clk),
    .reset    (reset),
    .we       (we),
    .waddr    (rd_q),
    .wdata    (wdata),
    .raddr    (raddr),
    .rdata    (rdata),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );

endmodule
